// File: rtl/apb_gpio_ext.sv
// rtl/apb_gpio_ext.sv - APB GPIO block with synchronizer, debounce and interrupts
//
// Purpose: WIDTH-pin general purpose I/O on an APB register slave. Pin inputs
// are double-flop synchronized, optionally debounced per pin, and feed
// edge/level interrupt detection with a per-pin enable mask.
//
// Ports:
//   PCLK, PRESET          clock, synchronous active-high reset
//   PSEL, PENABLE, PWRITE APB control
//   PADDR[7:2], PWDATA    APB word address and write data
//   PRDATA, PREADY,       APB read data, always-ready, error on unmapped offset
//   PSLVERR
//   PORTIN                raw asynchronous pin inputs
//   PORTOUT, PORTEN       pin output data and per-pin drive enable
//   GPIOINT, COMBINT      per-pin masked interrupts and their OR

module apb_gpio_ext #(
    parameter int WIDTH = 8,
    parameter int DBW   = 4
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             PSEL,
    input  logic [7:2]       PADDR,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    input  logic [WIDTH-1:0] PORTIN,
    output logic [WIDTH-1:0] PORTOUT,
    output logic [WIDTH-1:0] PORTEN,
    output logic [WIDTH-1:0] GPIOINT,
    output logic             COMBINT
);

    // Word indices of the register map (byte offset >> 2).
    localparam logic [5:0] REG_DATA    = 6'd0;
    localparam logic [5:0] REG_DOUT    = 6'd1;
    localparam logic [5:0] REG_OESET   = 6'd2;
    localparam logic [5:0] REG_OECLR   = 6'd3;
    localparam logic [5:0] REG_DOSET   = 6'd4;
    localparam logic [5:0] REG_DOCLR   = 6'd5;
    localparam logic [5:0] REG_IESET   = 6'd6;
    localparam logic [5:0] REG_IECLR   = 6'd7;
    localparam logic [5:0] REG_INTTYPE = 6'd8;
    localparam logic [5:0] REG_INTPOL  = 6'd9;
    localparam logic [5:0] REG_INTBOTH = 6'd10;
    localparam logic [5:0] REG_INTSTAT = 6'd11;
    localparam logic [5:0] REG_DBTHR   = 6'd12;
    localparam logic [5:0] REG_DBEN    = 6'd13;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] port_out;
    logic [WIDTH-1:0] port_en;
    logic [WIDTH-1:0] int_en;
    logic [WIDTH-1:0] int_type;
    logic [WIDTH-1:0] int_pol;
    logic [WIDTH-1:0] int_both;
    logic [WIDTH-1:0] int_stat;
    logic [DBW-1:0]   db_thr;
    logic [WIDTH-1:0] db_en;

    // Input path state
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_stable;
    logic [DBW-1:0]   db_cnt [WIDTH];

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic             addr_ok;
    logic             access;
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [DBW-1:0]   thr_wdata;
    logic             unused_pwdata;

    assign addr_ok   = (PADDR <= REG_DBEN);
    assign access    = PSEL & PENABLE;
    assign wr_en     = access & PWRITE & addr_ok;
    assign wdata     = PWDATA[WIDTH-1:0];
    assign thr_wdata = PWDATA[DBW-1:0];
    // Data bits beyond the pin count (or counter width) are dropped on write.
    assign unused_pwdata = ^PWDATA;

    assign PREADY  = 1'b1;
    assign PSLVERR = access & ~addr_ok & ~PRESET;

    // ------------------------------------------------------------------
    // Control register writes
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            port_out <= '0;
            port_en  <= '0;
            int_en   <= '0;
            int_type <= '0;
            int_pol  <= '0;
            int_both <= '0;
            db_thr   <= '0;
            db_en    <= '0;
        end else if (wr_en) begin
            case (PADDR)
                REG_DATA:    port_out <= wdata;
                REG_DOUT:    port_out <= wdata;
                REG_OESET:   port_en  <= port_en | wdata;
                REG_OECLR:   port_en  <= port_en & ~wdata;
                REG_DOSET:   port_out <= port_out | wdata;
                REG_DOCLR:   port_out <= port_out & ~wdata;
                REG_IESET:   int_en   <= int_en | wdata;
                REG_IECLR:   int_en   <= int_en & ~wdata;
                REG_INTTYPE: int_type <= wdata;
                REG_INTPOL:  int_pol  <= wdata;
                REG_INTBOTH: int_both <= wdata;
                REG_DBTHR:   db_thr   <= thr_wdata;
                REG_DBEN:    db_en    <= wdata;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Synchronizer and per-pin debounce
    // ------------------------------------------------------------------
    logic           db_thr_zero;
    logic [DBW-1:0] db_thr_m1;

    assign db_thr_zero = (db_thr == '0);
    assign db_thr_m1   = db_thr - DBW'(1);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync1       <= '0;
            sync2       <= '0;
            stable      <= '0;
            prev_stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1       <= PORTIN;
            sync2       <= sync1;
            prev_stable <= stable;
            for (int i = 0; i < WIDTH; i++) begin
                if (!db_en[i] || db_thr_zero) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= db_thr_m1) begin
                    // ">=" so a counter left above a freshly lowered
                    // threshold commits on its next mismatch and never wraps.
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Interrupt detection
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] level_hit;
    logic [WIDTH-1:0] stat_clr;

    assign rise      = stable & ~prev_stable;
    assign fall      = ~stable & prev_stable;
    assign edge_hit  = (int_both & (rise | fall))
                     | (~int_both & ((int_pol & rise) | (~int_pol & fall)));
    assign level_hit = ~(stable ^ int_pol);
    assign stat_clr  = (wr_en && (PADDR == REG_INTSTAT)) ? wdata : '0;

    // Edge pins: a new edge beats a simultaneous W1C; otherwise hold.
    // Level pins track the pin and ignore W1C. A level->edge switch keeps
    // whatever the level logic last produced.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            int_stat <= '0;
        end else begin
            int_stat <= (int_type & (edge_hit | (int_stat & ~stat_clr)))
                      | (~int_type & level_hit);
        end
    end

    assign GPIOINT = PRESET ? '0 : (int_stat & int_en);
    assign COMBINT = |GPIOINT;
    assign PORTOUT = port_out;
    assign PORTEN  = port_en;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        case (PADDR)
            REG_DATA:    rd_val = 32'(stable);
            REG_DOUT:    rd_val = 32'(port_out);
            REG_OESET:   rd_val = 32'(port_en);
            REG_OECLR:   rd_val = 32'(port_en);
            REG_DOSET:   rd_val = 32'(port_out);
            REG_DOCLR:   rd_val = 32'(port_out);
            REG_IESET:   rd_val = 32'(int_en);
            REG_IECLR:   rd_val = 32'(int_en);
            REG_INTTYPE: rd_val = 32'(int_type);
            REG_INTPOL:  rd_val = 32'(int_pol);
            REG_INTBOTH: rd_val = 32'(int_both);
            REG_INTSTAT: rd_val = 32'(int_stat);
            REG_DBTHR:   rd_val = 32'(db_thr);
            REG_DBEN:    rd_val = 32'(db_en);
            default:     rd_val = '0;
        endcase
    end

    assign PRDATA = (PSEL && !PWRITE && addr_ok && !PRESET) ? rd_val : '0;

endmodule

// File: tb/tb_apb_gpio_ext.sv
// tb/tb_apb_gpio_ext.sv - directed self-checking bench for apb_gpio_ext

module tb_apb_gpio_ext;

    localparam int WIDTH = 8;
    localparam int DBW   = 4;

    logic             PCLK = 1'b0;
    logic             PRESET;
    logic             PSEL;
    logic [7:2]       PADDR;
    logic             PENABLE;
    logic             PWRITE;
    logic [31:0]      PWDATA;
    logic [31:0]      PRDATA;
    logic             PREADY;
    logic             PSLVERR;
    logic [WIDTH-1:0] PORTIN;
    logic [WIDTH-1:0] PORTOUT;
    logic [WIDTH-1:0] PORTEN;
    logic [WIDTH-1:0] GPIOINT;
    logic             COMBINT;

    int checks   = 0;
    int failures = 0;

    apb_gpio_ext #(.WIDTH(WIDTH), .DBW(DBW)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PADDR   (PADDR),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .PORTIN  (PORTIN),
        .PORTOUT (PORTOUT),
        .PORTEN  (PORTEN),
        .GPIOINT (GPIOINT),
        .COMBINT (COMBINT)
    );

    always #5 PCLK = ~PCLK;

    task automatic bus_idle();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = addr[7:2]; PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        bus_idle();
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data,
                            output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr[7:2];
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1;
        data = PRDATA;
        err  = PSLVERR;
        @(posedge PCLK); #1;
        bus_idle();
    endtask

    task automatic watch_data();
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 6'd0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        e;
        bus_idle();
        PRESET = 1'b1;
        PORTIN = '0;
        repeat (3) @(posedge PCLK);
        #1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 6'd16;
        #1;
        checks++;
        if (PSLVERR !== 1'b0) begin
            failures++;
            $display("FAIL reset_pslverr actual=%b required=0", PSLVERR);
        end
        PADDR = 6'd1;
        #1;
        checks++;
        if (PRDATA !== 32'h0 || GPIOINT !== 8'h00 || COMBINT !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs prdata=%h gpioint=%h combint=%b required=0",
                     PRDATA, GPIOINT, COMBINT);
        end
        bus_idle();
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        checks++;
        if (PORTOUT !== 8'h00 || PORTEN !== 8'h00) begin
            failures++;
            $display("FAIL reset_port portout=%h porten=%h required=00", PORTOUT, PORTEN);
        end
        // Level-type, low-polarity default against low pins reports all set.
        apb_read(8'h2C, d, e);
        checks++;
        if (d !== 32'h0000_00FF) begin
            failures++;
            $display("FAIL reset_intstat actual=%h required=000000ff", d);
        end
        apb_read(8'h30, d, e);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_dbthr actual=%h required=0", d);
        end
    endtask

    task automatic test_output_regs();
        logic [31:0] d;
        logic        e;
        apb_write(8'h04, 32'hA5);
        apb_write(8'h08, 32'h0F);
        checks++;
        if (PORTOUT !== 8'hA5 || PORTEN !== 8'h0F) begin
            failures++;
            $display("FAIL out_set portout=%h porten=%h required=a5/0f", PORTOUT, PORTEN);
        end
        apb_write(8'h14, 32'h05);
        checks++;
        if (PORTOUT !== 8'hA0) begin
            failures++;
            $display("FAIL out_doclr actual=%h required=a0", PORTOUT);
        end
        apb_write(8'h10, 32'h10);
        checks++;
        if (PORTOUT !== 8'hB0) begin
            failures++;
            $display("FAIL out_doset actual=%h required=b0", PORTOUT);
        end
        apb_write(8'h0C, 32'h03);
        apb_read(8'h0C, d, e);
        checks++;
        if (d !== 32'h0C || PORTEN !== 8'h0C) begin
            failures++;
            $display("FAIL out_oeclr read=%h porten=%h required=0c", d, PORTEN);
        end
        apb_write(8'h04, 32'hFFFF_FF5A);
        apb_read(8'h04, d, e);
        checks++;
        if (d !== 32'h0000_005A) begin
            failures++;
            $display("FAIL out_upper_bits actual=%h required=0000005a", d);
        end
        apb_write(8'h30, 32'hFFFF_FFF3);
        apb_read(8'h30, d, e);
        checks++;
        if (d !== 32'h3) begin
            failures++;
            $display("FAIL dbthr_width actual=%h required=3", d);
        end
    endtask

    task automatic test_sync_latency();
        @(posedge PCLK); #1;
        watch_data();
        PORTIN = 8'h01;
        repeat (2) @(posedge PCLK);
        #1;
        checks++;
        if (PRDATA !== 32'h0) begin
            failures++;
            $display("FAIL sync_early actual=%h required=0", PRDATA);
        end
        @(posedge PCLK); #1;
        checks++;
        if (PRDATA !== 32'h1) begin
            failures++;
            $display("FAIL sync_3cyc actual=%h required=1", PRDATA);
        end
        bus_idle();
    endtask

    task automatic test_debounce();
        PORTIN = 8'h00;
        repeat (5) @(posedge PCLK);
        apb_write(8'h30, 32'h4);
        apb_write(8'h34, 32'h01);
        watch_data();
        @(posedge PCLK); #1;
        PORTIN = 8'h01;
        repeat (3) @(posedge PCLK);
        #1;
        PORTIN = 8'h00;
        repeat (8) @(posedge PCLK);
        #1;
        checks++;
        if (PRDATA !== 32'h0) begin
            failures++;
            $display("FAIL db_glitch actual=%h required=0", PRDATA);
        end
        @(posedge PCLK); #1;
        PORTIN = 8'h01;
        repeat (5) @(posedge PCLK);
        #1;
        checks++;
        if (PRDATA !== 32'h0) begin
            failures++;
            $display("FAIL db_before actual=%h required=0", PRDATA);
        end
        @(posedge PCLK); #1;
        checks++;
        if (PRDATA !== 32'h1) begin
            failures++;
            $display("FAIL db_6cyc actual=%h required=1", PRDATA);
        end
        PORTIN = 8'h00;
        repeat (10) @(posedge PCLK);
        bus_idle();
        apb_write(8'h34, 32'h00);
    endtask

    task automatic test_edge_irq();
        apb_write(8'h20, 32'h04);
        apb_write(8'h28, 32'h04);
        apb_write(8'h2C, 32'h04);
        apb_write(8'h18, 32'h04);
        checks++;
        if (GPIOINT !== 8'h00) begin
            failures++;
            $display("FAIL edge_idle actual=%h required=00", GPIOINT);
        end
        @(posedge PCLK); #1;
        PORTIN[2] = 1'b1;
        repeat (6) @(posedge PCLK);
        #1;
        checks++;
        if (GPIOINT !== 8'h04 || COMBINT !== 1'b1) begin
            failures++;
            $display("FAIL edge_rise gpioint=%h combint=%b required=04/1", GPIOINT, COMBINT);
        end
        apb_write(8'h2C, 32'h04);
        checks++;
        if (GPIOINT !== 8'h00) begin
            failures++;
            $display("FAIL edge_w1c actual=%h required=00", GPIOINT);
        end
        // Falling edge reaches INTSTAT on the 4th edge; W1C access lands there too.
        @(posedge PCLK); #1;
        PORTIN[2] = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 6'd11; PWDATA = 32'h04;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        bus_idle();
        checks++;
        if (GPIOINT !== 8'h04 || COMBINT !== 1'b1) begin
            failures++;
            $display("FAIL edge_set_wins gpioint=%h combint=%b required=04/1", GPIOINT, COMBINT);
        end
    endtask

    task automatic test_level_irq();
        apb_write(8'h2C, 32'h04);
        apb_write(8'h18, 32'h08);
        checks++;
        if (GPIOINT !== 8'h08) begin
            failures++;
            $display("FAIL level_low actual=%h required=08", GPIOINT);
        end
        apb_write(8'h2C, 32'h08);
        checks++;
        if (GPIOINT !== 8'h08) begin
            failures++;
            $display("FAIL level_w1c actual=%h required=08", GPIOINT);
        end
        @(posedge PCLK); #1;
        PORTIN[3] = 1'b1;
        repeat (6) @(posedge PCLK);
        #1;
        checks++;
        if (GPIOINT !== 8'h00 || COMBINT !== 1'b0) begin
            failures++;
            $display("FAIL level_high gpioint=%h combint=%b required=00/0", GPIOINT, COMBINT);
        end
    endtask

    task automatic test_error();
        logic [31:0] d;
        logic        e;
        apb_read(8'h40, d, e);
        checks++;
        if (e !== 1'b1 || d !== 32'h0) begin
            failures++;
            $display("FAIL err_read pslverr=%b prdata=%h required=1/0", e, d);
        end
        apb_read(8'h34, d, e);
        checks++;
        if (e !== 1'b0) begin
            failures++;
            $display("FAIL err_last_valid pslverr=%b required=0", e);
        end
    endtask

    task automatic test_reset_mid_write();
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 6'd1; PWDATA = 32'h3C;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PRESET  = 1'b1;
        @(posedge PCLK); #1;
        bus_idle();
        checks++;
        if (PORTOUT !== 8'h00 || GPIOINT !== 8'h00) begin
            failures++;
            $display("FAIL reset_write portout=%h gpioint=%h required=00", PORTOUT, GPIOINT);
        end
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        checks++;
        if (PORTOUT !== 8'h00 || PORTEN !== 8'h00) begin
            failures++;
            $display("FAIL reset_after portout=%h porten=%h required=00", PORTOUT, PORTEN);
        end
    endtask

    initial begin
        test_reset();
        test_output_regs();
        test_sync_latency();
        test_debounce();
        test_edge_irq();
        test_level_irq();
        test_error();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
